if_id_pipe_reg: RTL

//  Parametrised IF->ID pipeline register with a valid/ready handshake, stall absorption
//  and flush. A 2-entry skid buffer lets the fetch side see a registered in_ready while

---
 rtl/if_id_pkg.sv | 14 +
 rtl/pipe_skid_buf.sv | 75 +++++++
 rtl/if_id_pipe_reg.sv | 57 +++++
 3 files changed

// File: rtl/if_id_pkg.sv
// Shared types and defaults for the IF->ID pipeline register.
package if_id_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam int          IF_ID_INSTR_W   = 32;
  localparam int          IF_ID_ADDR_W    = 64;
  localparam logic [31:0] IF_ID_NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic W-bit 2-entry valid/ready skid buffer with flush; 1-cycle latency.
// in_ready is registered, so upstream never sees a combinational path from out_ready.
module pipe_skid_buf
  import if_id_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [W-1:0] flush_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_ready_q;
  logic         in_xfer;
  logic         out_xfer;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_xfer) state_nxt = FULL;
      FULL: begin
        if (in_xfer && !out_xfer)      state_nxt = SKID;
        else if (!in_xfer && out_xfer) state_nxt = EMPTY;
      end
      SKID:    if (out_xfer) state_nxt = FULL;
      default: state_nxt = EMPTY;
    endcase
    // Flush beats any transfer, including a beat offered this cycle.
    if (flush) state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != SKID);
      if (flush) begin
        main_q <= flush_data;
        skid_q <= '0;
      end else begin
        case (state)
          EMPTY: if (in_xfer) main_q <= in_data;
          FULL: begin
            if (in_xfer && out_xfer) main_q <= in_data;
            else if (in_xfer)        skid_q <= in_data;
          end
          SKID:    if (out_xfer) main_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register: skid-buffered instruction/PC with NOP-on-flush
// and a saturating stall counter for the performance monitor.
module if_id_pipe_reg
  import if_id_pkg::*;
#(
  parameter int                 INSTR_W   = IF_ID_INSTR_W,
  parameter int                 ADDR_W    = IF_ID_ADDR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(IF_ID_NOP_INSTR),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [ADDR_W-1:0]  PC_Out,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] IF_ID__instruction,
  output logic [ADDR_W-1:0]  IF_ID__PC_Out,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int               W       = INSTR_W + ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0] in_data;
  logic [W-1:0] flush_data;
  logic [W-1:0] out_data;

  assign in_data    = {instruction, PC_Out};
  assign flush_data = {NOP_INSTR, {ADDR_W{1'b0}}};
  assign {IF_ID__instruction, IF_ID__PC_Out} = out_data;

  pipe_skid_buf #(.W(W)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .flush_data (flush_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
